// File: rtl/gg_bitwin_pkg.sv
// Shared types and width helpers for the bit-window feeder.
//   bitwin_state_t : FILL (priming), RUN (streaming), FLUSH (draining the tail)
//   buf_bits()     : storage depth = window + lookahead + one input word
//   fw_bits()      : width of a counter that holds 0..BUF
package gg_bitwin_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } bitwin_state_t;

    function automatic int buf_bits(input int wid, input int pad, input int in_wid);
        return wid + pad + in_wid;
    endfunction

    function automatic int fw_bits(input int buf_w);
        return $clog2(buf_w + 1);
    endfunction

endpackage

// File: rtl/gg_bitwin_shiftbuf.sv
// MSB-first bit/tag shift buffer behind the window feeder.
//   pop            : drop the leading WID bits (shift left, zero-fill from LSB)
//   push           : append one input word right after the valid bits held
//   in_bits/start  : word and its tag, in_bits[IN_WID-1] earliest
//   in_last/len    : on the last word only the leading len bits are kept
//   sbuf/tbuf/fill : buffer contents and valid-bit count
//   fill_next      : count the buffer will hold after this cycle
// Bits below the fill point are always zero, so a push can be OR-ed in.
module gg_bitwin_shiftbuf
    import gg_bitwin_pkg::*;
#(
    parameter int BUF    = 96,
    parameter int WID    = 32,
    parameter int IN_WID = 32,
    parameter int FW     = fw_bits(BUF),
    parameter int LW     = $clog2(IN_WID + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pop,
    input  logic              push,
    input  logic [IN_WID-1:0] in_bits,
    input  logic [IN_WID-1:0] in_start,
    input  logic              in_last,
    input  logic [LW-1:0]     in_last_len,
    output logic [BUF-1:0]    sbuf,
    output logic [BUF-1:0]    tbuf,
    output logic [FW-1:0]     fill,
    output logic [FW-1:0]     fill_next
);

    logic [BUF-1:0]    sbuf_q, sbuf_d, tbuf_q, tbuf_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [BUF-1:0]    sbuf_pop_s, tbuf_pop_s;
    logic [FW-1:0]     fill_pop_s;
    logic [LW-1:0]     len_s;
    logic [IN_WID-1:0] mask_s;
    logic [BUF-1:0]    ins_bits_s, ins_tags_s;

    // Next buffer state: pop first, then land the push at the post-pop fill.
    always_comb begin
        sbuf_pop_s = sbuf_q;
        tbuf_pop_s = tbuf_q;
        fill_pop_s = fill_q;
        if (pop) begin
            sbuf_pop_s = sbuf_q << WID;
            tbuf_pop_s = tbuf_q << WID;
            if (fill_q >= FW'(WID)) begin
                fill_pop_s = fill_q - FW'(WID);
            end else begin
                fill_pop_s = {FW{1'b0}};
            end
        end else begin
            sbuf_pop_s = sbuf_q;
            tbuf_pop_s = tbuf_q;
            fill_pop_s = fill_q;
        end

        if (in_last) begin
            len_s = in_last_len;
        end else begin
            len_s = LW'(IN_WID);
        end
        // Keep the leading len_s bits; a full-length shift yields an all-ones mask.
        mask_s     = ~({IN_WID{1'b1}} >> len_s);
        ins_bits_s = {in_bits  & mask_s, {(BUF-IN_WID){1'b0}}} >> fill_pop_s;
        ins_tags_s = {in_start & mask_s, {(BUF-IN_WID){1'b0}}} >> fill_pop_s;

        if (push) begin
            sbuf_d = sbuf_pop_s | ins_bits_s;
            tbuf_d = tbuf_pop_s | ins_tags_s;
            fill_d = fill_pop_s + FW'(len_s);
        end else begin
            sbuf_d = sbuf_pop_s;
            tbuf_d = tbuf_pop_s;
            fill_d = fill_pop_s;
        end
    end

    // Buffer and fill-count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sbuf_q <= {BUF{1'b0}};
            tbuf_q <= {BUF{1'b0}};
            fill_q <= {FW{1'b0}};
        end else begin
            sbuf_q <= sbuf_d;
            tbuf_q <= tbuf_d;
            fill_q <= fill_d;
        end
    end

    assign sbuf      = sbuf_q;
    assign tbuf      = tbuf_q;
    assign fill      = fill_q;
    assign fill_next = fill_d;

endmodule

// File: rtl/gg_bit_window_feeder.sv
// Packed word stream -> WID-bit window + PAD-bit lookahead for the parse lattices.
//   in_valid/in_ready, in_bits, in_start, in_last, in_last_len : word input
//   out_valid/out_ready, out_bits, out_pad, out_start, out_last : window output
// Lookahead past the end of stream reads as zero; out_last marks the window
// holding the final stream bit. Handshake flags are registered from next state,
// so in_ready has no combinational path from out_ready.
module gg_bit_window_feeder
    import gg_bitwin_pkg::*;
#(
    parameter  int WID    = 32,
    parameter  int PAD    = 32,
    parameter  int IN_WID = 32,
    localparam int BUF    = buf_bits(WID, PAD, IN_WID),
    localparam int FW     = fw_bits(BUF),
    localparam int LW     = $clog2(IN_WID + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_WID-1:0] in_bits,
    input  logic [IN_WID-1:0] in_start,
    input  logic              in_last,
    input  logic [LW-1:0]     in_last_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WID-1:0]    out_bits,
    output logic [PAD-1:0]    out_pad,
    output logic [WID-1:0]    out_start,
    output logic              out_last
);

    bitwin_state_t  state_q, state_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic           pop_s, push_s;
    logic [BUF-1:0] sbuf_s, tbuf_s;
    logic [FW-1:0]  fill_s, fill_next_s;

    assign pop_s  = out_valid_q & out_ready;
    assign push_s = in_valid & in_ready_q;

    gg_bitwin_shiftbuf #(
        .BUF    (BUF),
        .WID    (WID),
        .IN_WID (IN_WID),
        .FW     (FW),
        .LW     (LW)
    ) u_shiftbuf (
        .clk         (clk),
        .reset_n     (reset_n),
        .pop         (pop_s),
        .push        (push_s),
        .in_bits     (in_bits),
        .in_start    (in_start),
        .in_last     (in_last),
        .in_last_len (in_last_len),
        .sbuf        (sbuf_s),
        .tbuf        (tbuf_s),
        .fill        (fill_s),
        .fill_next   (fill_next_s)
    );

    // Next state, then handshake flags evaluated against next state/fill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (push_s && in_last) begin
                    state_d = FLUSH;
                end else if (fill_next_s >= FW'(WID + PAD)) begin
                    state_d = RUN;
                end else begin
                    state_d = FILL;
                end
            end
            RUN: begin
                if (push_s && in_last) begin
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (fill_next_s == {FW{1'b0}}) begin
                    state_d = FILL;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: state_d = FILL;
        endcase

        in_ready_d  = (state_d != FLUSH) && (fill_next_s <= FW'(BUF - IN_WID));
        out_valid_d = ((state_d == RUN) && (fill_next_s >= FW'(WID + PAD))) ||
                      ((state_d == FLUSH) && (fill_next_s != {FW{1'b0}}));
        out_last_d  = (state_d == FLUSH) && (fill_next_s <= FW'(WID)) &&
                      (fill_next_s != {FW{1'b0}});
    end

    // FSM state and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_bits  = sbuf_s[BUF-1 -: WID];
    assign out_pad   = sbuf_s[BUF-1-WID -: PAD];
    assign out_start = tbuf_s[BUF-1 -: WID];

    // fill is carried for visibility only; window data comes from the buffer MSBs.
    logic unused_fill_s;
    assign unused_fill_s = ^fill_s;

endmodule

// File: tb/tb_gg_bit_window_feeder.sv
// Bench: a narrow feeder (32/32/32) and a wide one (128/32/128) share one
// left-aligned 128-bit driver; sel picks which one is active. The model keeps
// the accepted stream as a bit queue and derives each window by slicing it.
module tb_gg_bit_window_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         sel;
    logic         drv_valid, drv_last, out_ready;
    logic [127:0] drv_bits, drv_start;
    logic [7:0]   drv_len;
    int           rdy_mode;

    logic         a_in_ready, a_out_valid, a_out_last;
    logic [31:0]  a_out_bits, a_out_pad, a_out_start;
    logic         b_in_ready, b_out_valid, b_out_last;
    logic [127:0] b_out_bits, b_out_start;
    logic [31:0]  b_out_pad;

    gg_bit_window_feeder #(.WID(32), .PAD(32), .IN_WID(32)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid(drv_valid & ~sel), .in_ready(a_in_ready),
        .in_bits(drv_bits[127:96]), .in_start(drv_start[127:96]),
        .in_last(drv_last), .in_last_len(drv_len[5:0]),
        .out_valid(a_out_valid), .out_ready(out_ready & ~sel),
        .out_bits(a_out_bits), .out_pad(a_out_pad), .out_start(a_out_start),
        .out_last(a_out_last)
    );

    gg_bit_window_feeder #(.WID(128), .PAD(32), .IN_WID(128)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid(drv_valid & sel), .in_ready(b_in_ready),
        .in_bits(drv_bits), .in_start(drv_start),
        .in_last(drv_last), .in_last_len(drv_len),
        .out_valid(b_out_valid), .out_ready(out_ready & sel),
        .out_bits(b_out_bits), .out_pad(b_out_pad), .out_start(b_out_start),
        .out_last(b_out_last)
    );

    logic         m_in_ready, m_out_valid, m_out_last;
    logic [127:0] m_out_bits, m_out_start;
    logic [31:0]  m_out_pad;
    assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign m_out_valid = sel ? b_out_valid : a_out_valid;
    assign m_out_last  = sel ? b_out_last  : a_out_last;
    assign m_out_bits  = sel ? b_out_bits  : {a_out_bits, 96'd0};
    assign m_out_start = sel ? b_out_start : {a_out_start, 96'd0};
    assign m_out_pad   = sel ? b_out_pad   : a_out_pad;

    // Model: accepted stream bits/tags in order, window index, end-of-stream length.
    bit           mq[$];
    bit           tq[$];
    int           total, widx, cur_wid;
    bit           done;
    logic [127:0] got_bits[$];
    logic [127:0] got_start[$];
    logic [31:0]  got_pad[$];
    logic         got_last[$];
    int           vectors = 0;
    int           miscompares = 0;

    task automatic model_clear();
        mq.delete(); tq.delete();
        got_bits.delete(); got_start.delete(); got_pad.delete(); got_last.delete();
        total = 0; widx = 0; done = 1'b0;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare process: every valid window against the stream slice it must carry.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && m_out_valid === 1'b1) begin
            int base;
            logic [127:0] eb, es;
            logic [31:0]  ep;
            logic         el;
            base = widx * cur_wid;
            eb = '0; es = '0; ep = '0;
            for (int i = 0; i < cur_wid; i++) begin
                if (base + i < mq.size()) begin
                    eb[127-i] = mq[base+i];
                    es[127-i] = tq[base+i];
                end
            end
            for (int j = 0; j < 32; j++) begin
                if (base + cur_wid + j < mq.size()) ep[31-j] = mq[base+cur_wid+j];
            end
            el = done && (base + cur_wid >= total);
            vectors++;
            if (done && base >= total) begin
                miscompares++;
                $display("FAIL extra_window%0d: out_valid=1 required 0", widx);
            end else if (m_out_bits !== eb || m_out_pad !== ep || m_out_start !== es ||
                         m_out_last !== el) begin
                miscompares++;
                $display("FAIL window%0d: got bits=%h pad=%h start=%h last=%b required bits=%h pad=%h start=%h last=%b",
                         widx, m_out_bits, m_out_pad, m_out_start, m_out_last, eb, ep, es, el);
            end
            if (out_ready) begin
                got_bits.push_back(m_out_bits);
                got_start.push_back(m_out_start);
                got_pad.push_back(m_out_pad);
                got_last.push_back(m_out_last);
                widx++;
            end
        end
    end

    // out_ready pattern: 0 = always 1, 1 = toggling, other = held 0.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic do_reset(input logic s);
        @(posedge clk);
        #1;
        sel = s;
        drv_valid = 1'b0;
        reset_n = 1'b0;
        model_clear();
        cur_wid = s ? 128 : 32;
        @(negedge clk);
        chk("reset_in_ready", {127'd0, m_in_ready}, 128'd0);
        chk("reset_out_valid", {127'd0, m_out_valid}, 128'd0);
        chk("reset_out_bits", m_out_bits, 128'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic push_word(input logic [127:0] b, input logic [127:0] t,
                             input logic last, input int len);
        bit acc;
        int n;
        drv_bits = b; drv_start = t; drv_last = last; drv_len = 8'(len);
        drv_valid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 2000 && !acc; c++) begin
            @(negedge clk);
            if (m_in_ready === 1'b1) acc = 1'b1;
            @(posedge clk);
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: in_ready=0 required 1");
        end else begin
            n = last ? len : cur_wid;
            for (int i = 0; i < n; i++) begin
                mq.push_back(b[127-i]);
                tq.push_back(t[127-i]);
            end
            total += n;
            if (last) done = 1'b1;
        end
        #1;
        drv_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (done && widx * cur_wid >= total) ok = 1'b1;
        end
        chk("drain_done", {127'd0, ok}, 128'd1);
        repeat (3) @(negedge clk);
        chk("idle_out_valid", {127'd0, m_out_valid}, 128'd0);
        chk("idle_in_ready", {127'd0, m_in_ready}, 128'd1);
    endtask

    localparam logic [31:0] W0 = 32'hA5F0_3C81;
    localparam logic [31:0] W1 = 32'h0123_4567;
    localparam logic [31:0] W2 = 32'h89AB_CDEF;
    localparam logic [31:0] W3 = 32'hDEAD_BEEF;

    task automatic send_vec1();
        push_word({W0, 96'd0}, {32'h8000_0000, 96'd0}, 1'b0, 32);
        push_word({W1, 96'd0}, 128'd0, 1'b0, 32);
        push_word({W2, 96'd0}, 128'd0, 1'b0, 32);
        push_word({W3, 96'd0}, 128'd0, 1'b1, 32);
    endtask

    initial begin
        reset_n = 1'b0; sel = 1'b0; rdy_mode = 0;
        drv_valid = 1'b0; drv_last = 1'b0; drv_bits = '0; drv_start = '0; drv_len = '0;
        cur_wid = 32;
        model_clear();

        // 1: four-word coded-MB vector, sink always ready.
        do_reset(1'b0);
        send_vec1();
        wait_drain();
        chk("v1_count", 128'(got_bits.size()), 128'd4);
        if (got_bits.size() == 4) begin
            chk("v1_w0_bits", got_bits[0], {W0, 96'd0});
            chk("v1_w0_pad", {96'd0, got_pad[0]}, {96'd0, W1});
            chk("v1_w0_start", got_start[0], {32'h8000_0000, 96'd0});
            chk("v1_w1_start", got_start[1], 128'd0);
            chk("v1_w3_pad", {96'd0, got_pad[3]}, 128'd0);
            chk("v1_w3_last", {127'd0, got_last[3]}, 128'd1);
            chk("v1_w2_last", {127'd0, got_last[2]}, 128'd0);
        end

        // 2: 97-word PCM-style stream with toggling out_ready.
        do_reset(1'b0);
        rdy_mode = 1;
        for (int k = 0; k < 97; k++) begin
            push_word({(k == 0) ? 32'h0F00_0000 : 32'h0000_0000, 96'd0}, 128'd0,
                      (k == 96) ? 1'b1 : 1'b0, 32);
        end
        wait_drain();
        chk("v2_count", 128'(got_bits.size()), 128'd97);
        if (got_bits.size() == 97) begin
            chk("v2_w0_bits", got_bits[0], {32'h0F00_0000, 96'd0});
            chk("v2_w96_last", {127'd0, got_last[96]}, 128'd1);
        end

        // 3: short stream of 9 bits; tag bit beyond the length must be dropped.
        do_reset(1'b0);
        rdy_mode = 0;
        push_word({32'hFF80_0000, 96'd0}, {32'h8000_0001, 96'd0}, 1'b1, 9);
        wait_drain();
        chk("v3_count", 128'(got_bits.size()), 128'd1);
        if (got_bits.size() == 1) begin
            chk("v3_bits", got_bits[0], {32'hFF80_0000, 96'd0});
            chk("v3_pad", {96'd0, got_pad[0]}, 128'd0);
            chk("v3_start", got_start[0], {32'h8000_0000, 96'd0});
            chk("v3_last", {127'd0, got_last[0]}, 128'd1);
        end

        // 4: sink stalled until the buffer is full, then released.
        do_reset(1'b0);
        rdy_mode = 2;
        push_word({W0, 96'd0}, {32'h8000_0000, 96'd0}, 1'b0, 32);
        push_word({W1, 96'd0}, 128'd0, 1'b0, 32);
        push_word({W2, 96'd0}, 128'd0, 1'b0, 32);
        repeat (3) @(negedge clk);
        chk("v4_in_ready_full", {127'd0, m_in_ready}, 128'd0);
        chk("v4_out_valid", {127'd0, m_out_valid}, 128'd1);
        chk("v4_hold_bits", m_out_bits, {W0, 96'd0});
        rdy_mode = 0;
        push_word({W3, 96'd0}, 128'd0, 1'b1, 32);
        wait_drain();
        chk("v4_count", 128'(got_bits.size()), 128'd4);

        // 5: reset mid-stream with stray tags held, then a clean stream.
        do_reset(1'b0);
        rdy_mode = 2;
        push_word({W2, 96'd0}, {32'h0001_0000, 96'd0}, 1'b0, 32);
        push_word({W3, 96'd0}, {32'h0000_0004, 96'd0}, 1'b0, 32);
        do_reset(1'b0);
        rdy_mode = 0;
        send_vec1();
        wait_drain();
        chk("v5_count", 128'(got_bits.size()), 128'd4);
        if (got_bits.size() == 4) begin
            chk("v5_w0_start", got_start[0], {32'h8000_0000, 96'd0});
            chk("v5_w0_bits", got_bits[0], {W0, 96'd0});
        end

        // 6: wide configuration with vectors 1 and 3.
        do_reset(1'b1);
        push_word({W0, W1, W2, W3}, {32'h8000_0000, 96'd0}, 1'b1, 128);
        wait_drain();
        chk("v6a_count", 128'(got_bits.size()), 128'd1);
        if (got_bits.size() == 1) begin
            chk("v6a_bits", got_bits[0], {W0, W1, W2, W3});
            chk("v6a_start", got_start[0], {32'h8000_0000, 96'd0});
            chk("v6a_last", {127'd0, got_last[0]}, 128'd1);
        end
        do_reset(1'b1);
        push_word({32'hFF80_0000, 96'd0}, {32'h8000_0000, 96'd0}, 1'b1, 9);
        wait_drain();
        chk("v6b_count", 128'(got_bits.size()), 128'd1);
        if (got_bits.size() == 1) begin
            chk("v6b_bits", got_bits[0], {32'hFF80_0000, 96'd0});
            chk("v6b_last", {127'd0, got_last[0]}, 128'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
